// File: rtl/branch_cmp_scheduler_pkg.sv
// Shared types and sizing helpers for the two-lane nibble-serial branch comparator.
package branch_cmp_scheduler_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCompare,
        StDone
    } state_e;

    typedef struct packed {
        logic lane;
        logic equal;
        logic larger;
        logic smaller;
    } result_t;

    localparam result_t RESULT_RESET = '{lane: 1'b0, equal: 1'b1, larger: 1'b0, smaller: 1'b0};

    function automatic int unsigned nibbles(input int unsigned width);
        return width / 4;
    endfunction

endpackage

// File: rtl/comparator_4bit.sv
// Single-nibble magnitude compare; the signed flag flips the sign bit so the
// unsigned compare orders two's-complement values correctly.
module comparator_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_msb_signed,
    output logic       o_eq,
    output logic       o_gt,
    output logic       o_lt
);

    logic [3:0] a_m;
    logic [3:0] b_m;

    always_comb begin
        a_m  = {i_a[3] ^ i_msb_signed, i_a[2:0]};
        b_m  = {i_b[3] ^ i_msb_signed, i_b[2:0]};
        o_eq = (a_m == b_m);
        o_gt = (a_m > b_m);
        o_lt = (a_m < b_m);
    end

endmodule

// File: rtl/branch_cmp_scheduler.sv
// Round-robin two-lane branch compare scheduler; compares one nibble per cycle
// from the MSB down and stops at the first differing nibble.
module branch_cmp_scheduler
    import branch_cmp_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_req,
    input  logic [WIDTH-1:0] i_rs1_0,
    input  logic [WIDTH-1:0] i_rs2_0,
    input  logic [WIDTH-1:0] i_rs1_1,
    input  logic [WIDTH-1:0] i_rs2_1,
    input  logic [1:0]       i_signed,
    input  logic             i_flush,
    output logic [1:0]       o_gnt,
    output logic             o_busy,
    output logic             o_valid,
    output logic             o_lane,
    output logic             o_equal,
    output logic             o_larger,
    output logic             o_smaller
);

    localparam int unsigned NIBBLES = nibbles(WIDTH);
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(NIBBLES - 1);

    state_e           state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    result_t          pend_q, pend_d;
    result_t          held_q, held_d;

    logic [1:0] gnt;
    logic       sel;
    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic       cmp_eq;
    logic       cmp_gt;
    logic       cmp_lt;
    logic       show_pend;
    result_t    res_out;

    assign nib_a = a_q[{idx_q, 2'b00} +: 4];
    assign nib_b = b_q[{idx_q, 2'b00} +: 4];

    comparator_4bit u_cmp (
        .i_a          (nib_a),
        .i_b          (nib_b),
        .i_msb_signed (sgn_q && (idx_q == IDX_MSB)),
        .o_eq         (cmp_eq),
        .o_gt         (cmp_gt),
        .o_lt         (cmp_lt)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        a_d      = a_q;
        b_d      = b_q;
        sgn_d    = sgn_q;
        idx_d    = idx_q;
        pend_d   = pend_q;
        held_d   = held_q;
        gnt      = 2'b00;
        sel      = (i_req == 2'b11) ? rr_ptr_q : i_req[1];

        unique case (state_q)
            StIdle: begin
                if (!i_flush && (i_req != 2'b00)) begin
                    gnt         = sel ? 2'b10 : 2'b01;
                    a_d         = sel ? i_rs1_1 : i_rs1_0;
                    b_d         = sel ? i_rs2_1 : i_rs2_0;
                    sgn_d       = i_signed[sel];
                    idx_d       = IDX_MSB;
                    pend_d.lane = sel;
                    rr_ptr_d    = ~sel;
                    state_d     = StCompare;
                end
            end
            StCompare: begin
                if (i_flush) begin
                    state_d = StIdle;
                end else if (!cmp_eq) begin
                    pend_d.equal   = 1'b0;
                    pend_d.larger  = cmp_gt;
                    pend_d.smaller = cmp_lt;
                    state_d        = StDone;
                end else if (idx_q == '0) begin
                    pend_d.equal   = 1'b1;
                    pend_d.larger  = 1'b0;
                    pend_d.smaller = 1'b0;
                    state_d        = StDone;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (!i_flush) begin
                    held_d = pend_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            rr_ptr_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            idx_q    <= '0;
            pend_q   <= RESULT_RESET;
            held_q   <= RESULT_RESET;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sgn_q    <= sgn_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            held_q   <= held_d;
        end
    end

    // Results switch to the new value in the same cycle as o_valid; a flushed
    // DONE keeps showing the previous result.
    assign show_pend = (state_q == StDone) && !i_flush;
    assign res_out   = show_pend ? pend_q : held_q;

    assign o_gnt     = gnt & {2{i_rst_n}};
    assign o_busy    = (state_q != StIdle);
    assign o_valid   = show_pend;
    assign o_lane    = res_out.lane;
    assign o_equal   = res_out.equal;
    assign o_larger  = res_out.larger;
    assign o_smaller = res_out.smaller;

endmodule

// File: doc/branch_cmp_scheduler.md
BRANCH_CMP_SCHEDULER -- requirements
Module: branch_cmp_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; must be a multiple of 4.
REQ-002 SHALL have input i_clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have input i_rst_n, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have input i_req, 2 bits: per-lane compare request (bit 0 = lane 0, bit 1 = lane 1).
REQ-005 SHALL have inputs i_rs1_0 and i_rs2_0, WIDTH bits each: lane 0 operands A and B.
REQ-006 SHALL have inputs i_rs1_1 and i_rs2_1, WIDTH bits each: lane 1 operands A and B.
REQ-007 SHALL have input i_signed, 2 bits: per-lane two's-complement compare select.
REQ-008 SHALL have input i_flush, 1 bit: abort any in-flight compare.
REQ-009 SHALL have output o_gnt, 2 bits: one-hot, one-cycle pulse; operands of the granted lane are captured that cycle.
REQ-010 SHALL have output o_busy, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have output o_valid, 1 bit: one-cycle result strobe.
REQ-012 SHALL have outputs o_lane (1 bit), o_equal, o_larger and o_smaller (1 bit each): granted lane and A-versus-B result, held stable until the next o_valid.

Function
REQ-013 SHALL implement FSM states IDLE, COMPARE and DONE.
REQ-014 SHALL, in IDLE with any i_req bit set and i_flush low, grant exactly one lane, capture its operands and signed flag, load nibble index WIDTH/4-1, and go to COMPARE.
REQ-015 SHALL arbitrate round-robin: a lone requester wins; on a tie, the lane named by priority pointer rr_ptr wins; after each grant, rr_ptr points to the other lane.
REQ-016 SHALL, in COMPARE, evaluate one 4-bit nibble per cycle, starting at the MSB nibble and moving toward the LSB.
REQ-017 SHALL, when the current nibble differs, latch larger/smaller and go to DONE (early termination).
REQ-018 SHALL, when all nibbles are equal, latch equal at index 0 and go to DONE.
REQ-019 SHALL, for a signed compare, invert bit 3 of both operands on the MSB nibble only.
REQ-020 SHALL, in DONE, assert o_valid for one cycle and return to IDLE; no grant is issued in DONE.
REQ-021 SHALL meet these latencies: o_valid is asserted k+1 cycles after o_gnt, where k is the 1-based position of the deciding nibble counted from the MSB; minimum 2 cycles, maximum WIDTH/4+1 cycles.
REQ-022 SHALL keep exactly one of o_equal, o_larger and o_smaller high at any time after the first result.
REQ-023 SHALL, on i_flush high in any state, go to IDLE next cycle with no o_valid; rr_ptr and the result outputs are unchanged.
REQ-024 SHALL give i_flush precedence over i_req in IDLE: no grant is issued in that cycle.
REQ-025 SHALL ignore i_req while busy; a requester holds i_req until it sees its o_gnt bit.

Reset
REQ-026 SHALL, on i_rst_n low, immediately force state IDLE, rr_ptr=0, o_gnt=0, o_valid=0, o_busy=0, o_lane=0, o_equal=1, o_larger=0, o_smaller=0, and clear the captured operands and index.
REQ-027 SHALL accept a new request in the first cycle after i_rst_n deasserts; reset during COMPARE discards the operation with no o_valid.

Structure
REQ-028 SHALL place the state enum type and the NIBBLES=WIDTH/4 derivation in the shared datapath package.
REQ-029 SHALL instantiate exactly one comparator_4bit sub-module for the per-nibble decision, with no other comparison logic.

Verification
REQ-030 SHALL cover lane 0 alone, unsigned, A=0x8000_0000, B=0x7FFF_FFFF: o_gnt=01, o_valid 2 cycles later, larger=1.
REQ-031 SHALL cover the same operands signed: smaller=1 with 2-cycle latency.
REQ-032 SHALL cover A=B=0xDEAD_BEEF: equal=1 with 9-cycle latency.
REQ-033 SHALL cover both lanes requesting from reset: lane 0 is granted first, then lane 1 after DONE; o_lane follows 0 then 1.
REQ-034 SHALL cover A=0x0000_0011, B=0x0000_0010 with i_flush asserted on the 4th COMPARE cycle: no o_valid, IDLE next cycle, then a new grant is accepted.
REQ-035 SHALL cover i_rst_n asserted mid-COMPARE: outputs are at reset values within the same cycle and no o_valid is produced.
